// File: rtl/mem_access_unit.sv
// Memory-stage data access unit: turns MEM-stage load/store controls into a single
// outstanding ready-handshake bus transaction, stalls the pipeline, and extends load data.
module mem_access_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] RD,
  output logic        MisalignedM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  a_q, a_d;
  logic        we_q, we_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] rd_q, rd_d;
  logic        mis_q, mis_d;

  logic        access;
  logic        misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign access = MemReadM | MemWriteM;

  // Alignment, byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = WriteDataM;
    unique case (MemSizeM)
      2'b00: begin
        be_new    = 4'b0001 << ALUOutM[1:0];
        wdata_new = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        misaligned = ALUOutM[0];
        be_new     = 4'b0011 << ALUOutM[1:0];
        wdata_new  = {2{WriteDataM[15:0]}};
      end
      default: begin
        misaligned = |ALUOutM[1:0];
      end
    endcase
  end

  // Load extraction uses the latched size/offset, not the live pipeline inputs.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    unique case (a_q)
      2'b00: ld_byte = mem_rdata[7:0];
      2'b01: ld_byte = mem_rdata[15:8];
      2'b10: ld_byte = mem_rdata[23:16];
      2'b11: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_q)
      2'b00:   ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    signed_d    = signed_q;
    a_d         = a_q;
    we_d        = we_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rd_d        = rd_q;
    mis_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (misaligned) begin
            mis_d = 1'b1;
            rd_d  = 32'h0;
          end else begin
            size_d      = MemSizeM;
            signed_d    = MemSignedM;
            a_d         = ALUOutM[1:0];
            we_d        = MemWriteM;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWriteM;
            mem_addr_d  = {ALUOutM[31:2], 2'b00};
            mem_wdata_d = wdata_new;
            mem_be_d    = be_new;
            state_d     = StReq;
          end
        end
      end
      StReq: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (!we_q) rd_d = ld_data;
          state_d = StDone;
        end
      end
      StDone: begin
        // Inputs still show the completed instruction here; never re-launch it.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      a_q         <= 2'b00;
      we_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      rd_q        <= 32'h0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      a_q         <= a_d;
      we_q        <= we_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rd_q        <= rd_d;
      mis_q       <= mis_d;
    end
  end

  assign StallM      = reset_n & (((state_q == StIdle) & access & ~misaligned) |
                                  (state_q == StReq));
  assign RD          = rd_q;
  assign MisalignedM = mis_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of accesses with hand-computed results,
// plus hand-written reset-mid-transaction and back-to-back sequences.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [1:0]  MemSizeM = 2'b00;
  logic        MemSignedM = 1'b0;
  logic [31:0] ALUOutM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic        StallM;
  logic [31:0] RD;
  logic        MisalignedM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  mem_access_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .MemReadM    (MemReadM),
    .MemWriteM   (MemWriteM),
    .MemSizeM    (MemSizeM),
    .MemSignedM  (MemSignedM),
    .ALUOutM     (ALUOutM),
    .WriteDataM  (WriteDataM),
    .StallM      (StallM),
    .RD          (RD),
    .MisalignedM (MisalignedM),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] rd_model = 32'h0;
  vec_t        vecs[13];

  function automatic vec_t mk(string name, logic rd, logic wr, logic [1:0] size, logic sgn,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                              int waits, logic mis, logic [31:0] exp_addr,
                              logic [3:0] exp_be, logic [31:0] exp_wdata,
                              logic [31:0] exp_rd);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.waits = waits; v.mis = mis;
    v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    MemReadM = 1'b0; MemWriteM = 1'b0; mem_ready = 1'b0;
    #1;
    chk("idle_req", {31'h0, mem_req}, 32'h0);
    chk("idle_stall", {31'h0, StallM}, 32'h0);
  endtask

  // Drives one instruction from its IDLE cycle; inputs stay held until the pipeline advances.
  task automatic run_vec(input vec_t v);
    @(negedge clock);
    MemReadM = v.rd; MemWriteM = v.wr; MemSizeM = v.size; MemSignedM = v.sgn;
    ALUOutM = v.addr; WriteDataM = v.wdata; mem_rdata = v.rdata;
    mem_ready = 1'b1; // must be ignored outside REQ
    #1;
    if (v.mis) begin
      chk({v.name, "_stall0"}, {31'h0, StallM}, 32'h0);
      chk({v.name, "_req0"}, {31'h0, mem_req}, 32'h0);
      @(negedge clock);
      MemReadM = 1'b0; MemWriteM = 1'b0;
      #1;
      rd_model = 32'h0;
      chk({v.name, "_mis"}, {31'h0, MisalignedM}, 32'h1);
      chk({v.name, "_rd"}, RD, rd_model);
      chk({v.name, "_req1"}, {31'h0, mem_req}, 32'h0);
      chk({v.name, "_stall1"}, {31'h0, StallM}, 32'h0);
      @(negedge clock);
      #1;
      chk({v.name, "_mis_once"}, {31'h0, MisalignedM}, 32'h0);
      return;
    end
    chk({v.name, "_stall_idle"}, {31'h0, StallM}, 32'h1);
    chk({v.name, "_req_idle"}, {31'h0, mem_req}, 32'h0);
    for (int k = 1; k <= v.waits + 1; k++) begin
      @(negedge clock);
      mem_ready = (k == v.waits + 1);
      #1;
      chk({v.name, "_req"}, {31'h0, mem_req}, 32'h1);
      chk({v.name, "_stall_req"}, {31'h0, StallM}, 32'h1);
      chk({v.name, "_rd_hold"}, RD, rd_model);
      chk({v.name, "_we"}, {31'h0, mem_we}, {31'h0, v.wr});
      chk({v.name, "_addr"}, mem_addr, v.exp_addr);
      chk({v.name, "_be"}, {28'h0, mem_be}, {28'h0, v.exp_be});
      if (v.wr) chk({v.name, "_wdata"}, mem_wdata, v.exp_wdata);
    end
    @(negedge clock);
    mem_ready = 1'b1;
    #1;
    if (!v.wr) rd_model = v.exp_rd;
    chk({v.name, "_req_done"}, {31'h0, mem_req}, 32'h0);
    chk({v.name, "_stall_done"}, {31'h0, StallM}, 32'h0);
    chk({v.name, "_rd_done"}, RD, rd_model);
    chk({v.name, "_mis_done"}, {31'h0, MisalignedM}, 32'h0);
  endtask

  initial begin
    //             name    rd wr size sgn addr          wdata         rdata        w mis
    vecs[0]  = mk("lw",    1, 0, 2'b10, 0, 32'h1000_0004, 32'h0,        32'hDEAD_BEEF, 0, 0,
                  32'h1000_0004, 4'hF, 32'h0, 32'hDEAD_BEEF);
    vecs[1]  = mk("lb",    1, 0, 2'b00, 1, 32'h2000_0003, 32'h0,        32'h8012_3456, 2, 0,
                  32'h2000_0000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    vecs[2]  = mk("lbu",   1, 0, 2'b00, 0, 32'h2000_0003, 32'h0,        32'h8012_3456, 2, 0,
                  32'h2000_0000, 4'b1000, 32'h0, 32'h0000_0080);
    vecs[3]  = mk("sh",    0, 1, 2'b01, 0, 32'h3000_0002, 32'h1234_ABCD, 32'h0,        0, 0,
                  32'h3000_0000, 4'b1100, 32'hABCD_ABCD, 32'h0);
    vecs[4]  = mk("lh",    1, 0, 2'b01, 1, 32'h4000_0002, 32'h0,        32'h8001_7FFF, 1, 0,
                  32'h4000_0000, 4'b1100, 32'h0, 32'hFFFF_8001);
    vecs[5]  = mk("lhu",   1, 0, 2'b01, 0, 32'h4000_0000, 32'h0,        32'h8001_7FFF, 0, 0,
                  32'h4000_0000, 4'b0011, 32'h0, 32'h0000_7FFF);
    vecs[6]  = mk("sb",    0, 1, 2'b00, 0, 32'h5000_0001, 32'hAABB_CCDD, 32'h0,        1, 0,
                  32'h5000_0000, 4'b0010, 32'hDDDD_DDDD, 32'h0);
    vecs[7]  = mk("lbu1",  1, 0, 2'b00, 0, 32'h6000_0001, 32'h0,        32'h1122_3344, 0, 0,
                  32'h6000_0000, 4'b0010, 32'h0, 32'h0000_0033);
    vecs[8]  = mk("sw11",  0, 1, 2'b11, 0, 32'h7000_0008, 32'hCAFE_F00D, 32'h0,        0, 0,
                  32'h7000_0008, 4'hF, 32'hCAFE_F00D, 32'h0);
    vecs[9]  = mk("rdwr",  1, 1, 2'b10, 1, 32'h7000_000C, 32'h0102_0304, 32'hFFFF_FFFF, 0, 0,
                  32'h7000_000C, 4'hF, 32'h0102_0304, 32'h0);
    vecs[10] = mk("lw_mis", 1, 0, 2'b10, 0, 32'h1000_0006, 32'h0,       32'h0,        0, 1,
                  32'h0, 4'h0, 32'h0, 32'h0);
    vecs[11] = mk("lh_mis", 1, 0, 2'b01, 1, 32'h1000_0001, 32'h0,       32'h0,        0, 1,
                  32'h0, 4'h0, 32'h0, 32'h0);
    vecs[12] = mk("sw_mis", 0, 1, 2'b11, 0, 32'h1000_0002, 32'h0,       32'h0,        0, 1,
                  32'h0, 4'h0, 32'h0, 32'h0);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_stall", {31'h0, StallM}, 32'h0);
    chk("rst_rd", RD, 32'h0);
    chk("rst_mis", {31'h0, MisalignedM}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      idle_cycle();
      run_vec(vecs[i]);
    end

    // Reset in the middle of a load that is still waiting for mem_ready
    idle_cycle();
    run_vec(vecs[0]);
    @(negedge clock);
    MemReadM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'b10; ALUOutM = 32'h0000_0010;
    mem_ready = 1'b0;
    @(negedge clock);
    mem_ready = 1'b0;
    #1;
    chk("mid_req_up", {31'h0, mem_req}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    rd_model = 32'h0;
    chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_stall", {31'h0, StallM}, 32'h0);
    chk("mid_rst_rd", RD, rd_model);
    @(negedge clock);
    MemReadM = 1'b0;
    reset_n = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      chk("post_rst_req", {31'h0, mem_req}, 32'h0);
      chk("post_rst_stall", {31'h0, StallM}, 32'h0);
    end
    run_vec(vecs[0]);

    // Back-to-back: lw then sw with no idle instruction between
    idle_cycle();
    run_vec(mk("b2b_lw", 1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'h5A5A_1234, 0, 0,
               32'h0000_0100, 4'hF, 32'h0, 32'h5A5A_1234));
    run_vec(mk("b2b_sw", 0, 1, 2'b10, 0, 32'h0000_0104, 32'h7777_8888, 32'h0, 0, 0,
               32'h0000_0104, 4'hF, 32'h7777_8888, 32'h0));
    chk("b2b_rd_held", RD, 32'h5A5A_1234);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
